// File: rtl/line_rasterizer_pkg.sv
// Shared types and defaults for the Bresenham line rasterizer.
package line_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        DRAW  = 2'b10,
        DONE  = 2'b11
    } line_state_t;

    localparam int COORD_W_DEFAULT = 11;

endpackage

// File: rtl/line_rasterizer_if.sv
// Segment-feed and pixel-write signals of the line rasterizer, bundled as one interface.
// The slave modport is the rasterizer; the master modport is its environment
// (segment producer plus frame-buffer write port).
interface line_rasterizer_if
    import line_pkg::*;
#(
    parameter int N = COORD_W_DEFAULT
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x0;
    logic [N-1:0] y0;
    logic [N-1:0] x1;
    logic [N-1:0] y1;
    logic         pix_valid;
    logic         pix_ready;
    logic [N-1:0] pix_x;
    logic [N-1:0] pix_y;
    logic         busy;
    logic         done;

    modport master (
        output in_valid, x0, y0, x1, y1, pix_ready,
        input  in_ready, pix_valid, pix_x, pix_y, busy, done
    );

    modport slave (
        input  in_valid, x0, y0, x1, y1, pix_ready,
        output in_ready, pix_valid, pix_x, pix_y, busy, done
    );

endinterface

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts one segment per handshake and emits every
// pixel of it, endpoints inclusive, with backpressure on the pixel port.
module line_rasterizer
    import line_pkg::*;
#(
    parameter int N = COORD_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    line_rasterizer_if.slave  bus
);

    // Error terms carry two extra bits so |dx|+|dy| never overflows; the
    // doubled error needs one more.
    localparam int W  = N + 2;
    localparam int EW = N + 3;
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    line_state_t state_r;
    line_state_t state_next_s;

    logic [N-1:0]        x0_r, y0_r, x1_r, y1_r;
    logic [N-1:0]        cur_x_r, cur_y_r;
    logic signed [W-1:0] dx_r, dy_r, err_r;
    logic                sx_neg_r, sy_neg_r;
    logic                in_ready_r, pix_valid_r, busy_r, done_r;

    logic signed [W-1:0]  dx_setup_s, dy_setup_s, err_setup_s, err_step_s;
    logic                 sx_neg_setup_s, sy_neg_setup_s;
    logic [N-1:0]         cur_x_step_s, cur_y_step_s;
    logic signed [EW-1:0] e2_s, dx_wide_s, dy_wide_s;
    logic                 at_end_s;
    logic                 accept_s;

    function automatic logic [N-1:0] abs_diff(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] d;
        if (a < b) begin
            d = b - a;
        end else begin
            d = a - b;
        end
        return d;
    endfunction

    assign accept_s = bus.in_valid && in_ready_r;
    assign at_end_s = (cur_x_r == x1_r) && (cur_y_r == y1_r);

    // Setup terms from the latched endpoints and the single Bresenham step from the current point.
    always_comb begin
        dx_setup_s     = signed'({2'b00, abs_diff(x0_r, x1_r)});
        dy_setup_s     = {W{1'b0}} - signed'({2'b00, abs_diff(y0_r, y1_r)});
        err_setup_s    = dx_setup_s + dy_setup_s;
        sx_neg_setup_s = !(x0_r < x1_r);
        sy_neg_setup_s = !(y0_r < y1_r);

        e2_s      = {err_r, 1'b0};
        dx_wide_s = {dx_r[W-1], dx_r};
        dy_wide_s = {dy_r[W-1], dy_r};

        err_step_s   = err_r;
        cur_x_step_s = cur_x_r;
        cur_y_step_s = cur_y_r;

        if (e2_s >= dy_wide_s) begin
            err_step_s = err_step_s + dy_r;
            if (sx_neg_r) begin
                cur_x_step_s = cur_x_r - ONE_N;
            end else begin
                cur_x_step_s = cur_x_r + ONE_N;
            end
        end else begin
            cur_x_step_s = cur_x_r;
        end

        if (e2_s <= dx_wide_s) begin
            err_step_s = err_step_s + dx_r;
            if (sy_neg_r) begin
                cur_y_step_s = cur_y_r - ONE_N;
            end else begin
                cur_y_step_s = cur_y_r + ONE_N;
            end
        end else begin
            cur_y_step_s = cur_y_r;
        end
    end

    // Next-state selection of the segment FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                state_next_s = DRAW;
            end
            DRAW: begin
                if (bus.pix_ready && at_end_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAW;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            pix_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            x0_r        <= {N{1'b0}};
            y0_r        <= {N{1'b0}};
            x1_r        <= {N{1'b0}};
            y1_r        <= {N{1'b0}};
            cur_x_r     <= {N{1'b0}};
            cur_y_r     <= {N{1'b0}};
            dx_r        <= {W{1'b0}};
            dy_r        <= {W{1'b0}};
            err_r       <= {W{1'b0}};
            sx_neg_r    <= 1'b0;
            sy_neg_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            pix_valid_r <= (state_next_s == DRAW);
            busy_r      <= (state_next_s != IDLE);
            done_r      <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        x0_r <= bus.x0;
                        y0_r <= bus.y0;
                        x1_r <= bus.x1;
                        y1_r <= bus.y1;
                    end
                end
                SETUP: begin
                    dx_r     <= dx_setup_s;
                    dy_r     <= dy_setup_s;
                    err_r    <= err_setup_s;
                    sx_neg_r <= sx_neg_setup_s;
                    sy_neg_r <= sy_neg_setup_s;
                    cur_x_r  <= x0_r;
                    cur_y_r  <= y0_r;
                end
                DRAW: begin
                    // The final endpoint stays on the port; only inner pixels advance.
                    if (bus.pix_ready && !at_end_s) begin
                        err_r   <= err_step_s;
                        cur_x_r <= cur_x_step_s;
                        cur_y_r <= cur_y_step_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.pix_valid = pix_valid_r;
    assign bus.pix_x     = cur_x_r;
    assign bus.pix_y     = cur_y_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: expected pixels go to a queue when a
// segment is sent and are popped as the rasterizer hands pixels over.
module tb_line_rasterizer;
    import line_pkg::*;

    localparam int N = COORD_W_DEFAULT;

    logic clock = 1'b0;
    logic reset = 1'b1;

    line_rasterizer_if #(.N(N)) bus ();

    line_rasterizer #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int acc_count = 0;
    int done_count = 0;
    int cycle = 0;
    int last_acc_cycle = 0;
    int ready_mode = 0;
    int pat_idx = 0;
    bit sb_enable = 1'b1;
    bit rate_check = 1'b0;
    bit mono_check = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_done = 1'b0;
    int prev_pix = 0;
    int prev_x = 0;
    int prev_y = 0;

    task automatic check_eq(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int pk(input int x, input int y);
        return x * 65536 + y;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference Bresenham walk in plain integers.
    task automatic push_model(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y;
        dx = iabs(x1 - x0);
        dy = -iabs(y1 - y0);
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        for (int i = 0; i < 5000; i++) begin
            exp_q.push_back(pk(x, y));
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    always @(posedge clock) cycle <= cycle + 1;

    // Pixel-port backpressure: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: bus.pix_ready = 1'b1;
                1: begin
                    bus.pix_ready = (pat_idx % 3 == 0);
                    pat_idx++;
                end
                default: bus.pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clock) begin
        int px, py;
        px = int'(bus.pix_x);
        py = int'(bus.pix_y);
        if (!reset) begin
            if (prev_stall && sb_enable) begin
                check_eq("stall_valid", int'(bus.pix_valid), 1);
                check_eq("stall_hold", pk(px, py), prev_pix);
            end
            if (prev_done) begin
                check_eq("done_width", int'(bus.done), 0);
                check_eq("ready_after_done", int'(bus.in_ready), 1);
            end
            if (bus.done) begin
                check_eq("done_no_pix", int'(bus.pix_valid), 0);
                if (sb_enable) check_eq("done_latency", cycle - last_acc_cycle, 1);
                done_count++;
            end
            if (bus.pix_valid) check_eq("busy_in_draw", int'(bus.busy), 1);
            if (bus.pix_valid && bus.pix_ready && sb_enable) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_pixel", pk(px, py), -1);
                end else begin
                    check_eq("pixel", pk(px, py), exp_q.pop_front());
                end
                if (rate_check && acc_count > 0) check_eq("rate", cycle - last_acc_cycle, 1);
                if (mono_check && acc_count > 0) begin
                    check_eq("mono_x", int'((prev_x - px) == 0 || (prev_x - px) == 1), 1);
                    check_eq("mono_y", int'((py - prev_y) == 0 || (py - prev_y) == 1), 1);
                end
                acc_count++;
                last_acc_cycle = cycle;
                prev_x = px;
                prev_y = py;
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_pix = pk(px, py);
            prev_done = bus.done;
        end else begin
            prev_stall = 1'b0;
            prev_done = 1'b0;
        end
    end

    task automatic send_seg(input int x0, input int y0, input int x1, input int y1);
        bit ok;
        ok = 1'b0;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b1;
        bus.x0 = x0[N-1:0];
        bus.y0 = y0[N-1:0];
        bus.x1 = x1[N-1:0];
        bus.y1 = y1[N-1:0];
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("accept_timeout", 0, 1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        check_eq("in_ready_drop", int'(bus.in_ready), 0);
        check_eq("busy_rise", int'(bus.busy), 1);
    endtask

    task automatic wait_done(input int budget);
        int start;
        bit ok;
        start = done_count;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #1;
            if (done_count != start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("done_timeout", 0, 1);
        repeat (2) @(posedge clock);
        #1;
        check_eq("queue_empty", exp_q.size(), 0);
        check_eq("idle_ready", int'(bus.in_ready), 1);
    endtask

    // One segment: expected pixels come from the model unless the caller queued them.
    task automatic run_seg(input int x0, input int y0, input int x1, input int y1,
                           input int mode, input bit use_model, input int budget);
        int n_exp;
        ready_mode = mode;
        pat_idx = 0;
        rate_check = (mode == 0);
        acc_count = 0;
        n_exp = ((iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0)) + 1;
        if (use_model) push_model(x0, y0, x1, y1);
        send_seg(x0, y0, x1, y1);
        wait_done(budget);
        check_eq("pix_count", acc_count, n_exp);
    endtask

    initial begin
        int d0;
        bit ok;
        bus.in_valid = 1'b0;
        bus.x0 = '0;
        bus.y0 = '0;
        bus.x1 = '0;
        bus.y1 = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_eq("rst_in_ready", int'(bus.in_ready), 1);
        check_eq("rst_pix_valid", int'(bus.pix_valid), 0);
        check_eq("rst_pix_xy", pk(int'(bus.pix_x), int'(bus.pix_y)), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_done", int'(bus.done), 0);

        // Horizontal run at full rate.
        exp_q.push_back(pk(0, 0)); exp_q.push_back(pk(1, 0));
        exp_q.push_back(pk(2, 0)); exp_q.push_back(pk(3, 0));
        run_seg(0, 0, 3, 0, 0, 1'b0, 40);

        // Reverse direction, shallow slope.
        exp_q.push_back(pk(5, 5)); exp_q.push_back(pk(4, 4));
        exp_q.push_back(pk(3, 4)); exp_q.push_back(pk(2, 3));
        run_seg(5, 5, 2, 3, 0, 1'b0, 40);

        // Steep slope.
        exp_q.push_back(pk(0, 0)); exp_q.push_back(pk(0, 1));
        exp_q.push_back(pk(1, 2)); exp_q.push_back(pk(1, 3));
        run_seg(0, 0, 1, 3, 0, 1'b0, 40);

        // Degenerate single-pixel segment.
        exp_q.push_back(pk(7, 9));
        run_seg(7, 9, 7, 9, 0, 1'b0, 40);

        // Diagonal under 1,0,0 backpressure.
        for (int i = 0; i <= 4; i++) exp_q.push_back(pk(i, i));
        run_seg(0, 0, 4, 4, 1, 1'b0, 80);

        // Reset during the third pixel of a long horizontal run.
        ready_mode = 0;
        rate_check = 1'b0;
        acc_count = 0;
        push_model(0, 0, 10, 0);
        send_seg(0, 0, 10, 0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (acc_count >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("abort_wait_timeout", 0, 1);
        check_eq("abort_third_pix", pk(int'(bus.pix_x), int'(bus.pix_y)), pk(2, 0));
        sb_enable = 1'b0;
        d0 = done_count;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("abort_pix_valid", int'(bus.pix_valid), 0);
        check_eq("abort_busy", int'(bus.busy), 0);
        check_eq("abort_done", int'(bus.done), 0);
        check_eq("abort_pix_xy", pk(int'(bus.pix_x), int'(bus.pix_y)), 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clock);
        #1;
        check_eq("abort_no_done", done_count, d0);
        check_eq("abort_idle_valid", int'(bus.pix_valid), 0);
        check_eq("abort_in_ready", int'(bus.in_ready), 1);
        sb_enable = 1'b1;
        run_seg(3, 1, 8, 4, 0, 1'b1, 40);

        // Random short segments in all octants with mixed backpressure.
        for (int i = 0; i < 8; i++) begin
            run_seg(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 2)), 1'b1, 400);
        end

        // Full-screen anti-diagonal.
        mono_check = 1'b1;
        run_seg(2047, 0, 0, 2047, 0, 1'b1, 3000);
        mono_check = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
